port_uart_tx: RTL and testbench

Downstream consumer of the CPU top-level 8-bit output PORT. It detects every change of the PORT value and queues the new value in a small FIFO. It then serialises each queued value as a UART 8N1 frame on a single TX line, so that program output can be watched on a terminal or in the bench.
It sits beside the CPU top level, with PORT_IN wired directly to the CPU PORT output.

---
 rtl/port_uart_pkg.sv | 17 +
 rtl/port_uart_tx_if.sv | 18 +
 rtl/port_uart_tx_fifo.sv | 59 +++++
 rtl/port_uart_tx.sv | 143 ++++++++++++++
 tb/tb_port_uart_tx.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/port_uart_pkg.sv
// Shared types and constants for the PORT-to-UART transmitter.
// The PARITY state is used only when PORT_UART_PARITY_EN is defined.
package port_uart_pkg;

  localparam int   DATA_W         = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/port_uart_tx_if.sv
// Signal bundle between the CPU output port and the UART transmitter.
// The master side drives PORT_IN; the slave side (the transmitter) drives the status outputs.
interface port_uart_tx_if
  import port_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);

  logic [DATA_W-1:0]           PORT_IN;
  logic                        TX;
  logic                        BUSY;
  logic                        OVF;
  logic [$clog2(FIFO_DEPTH):0] FIFO_CNT;

  modport master (output PORT_IN, input TX, BUSY, OVF, FIFO_CNT);
  modport slave  (input PORT_IN, output TX, BUSY, OVF, FIFO_CNT);

endinterface

// File: rtl/port_uart_tx_fifo.sv
// Small synchronous FIFO for port_uart_tx. Head data is presented combinationally
// so that the transmitter can load it on the same edge that it pops.
module port_fifo
  import port_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic [DATA_W-1:0]        PUSH_DATA,
  input  logic                     POP,
  output logic [DATA_W-1:0]        POP_DATA,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   CNT
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       cnt_reg;
  logic              push_ok;
  logic              pop_ok;

  // Fullness is judged on the pre-edge count, even when a pop happens on the same edge.
  assign push_ok  = PUSH && !FULL;
  assign pop_ok   = POP && !EMPTY;
  assign FULL     = (cnt_reg == FULL_CNT);
  assign EMPTY    = (cnt_reg == '0);
  assign CNT      = cnt_reg;
  assign POP_DATA = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= PUSH_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/port_uart_tx.sv
// Watches the CPU output port, queues every new value and sends each one as a UART frame.
// Define PORT_UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module port_uart_tx
  import port_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  port_uart_tx_if.slave   bus
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [DATA_W-1:0]             last_reg;
  logic                          primed_reg;
  logic                          ovf_reg;
  uart_state_t                   state_reg;
  logic [DATA_W-1:0]             shift_reg;
  logic [2:0]                    bit_idx_reg;
  logic [15:0]                   div_cnt_reg;
  logic                          tx_reg;

  logic                          push;
  logic                          pop;
  logic [DATA_W-1:0]             pop_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;

  assign push = primed_reg && (bus.PORT_IN != last_reg);
  assign pop  = (state_reg == IDLE) && !fifo_empty;

  port_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .PUSH     (push),
    .PUSH_DATA(bus.PORT_IN),
    .POP      (pop),
    .POP_DATA (pop_data),
    .FULL     (fifo_full),
    .EMPTY    (fifo_empty),
    .CNT      (fifo_cnt)
  );

  // The first value after reset only primes the detector, so it is never sent.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_reg   <= '0;
      primed_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (!primed_reg) begin
      last_reg   <= bus.PORT_IN;
      primed_reg <= 1'b1;
    end else if (push) begin
      last_reg <= bus.PORT_IN;
      if (fifo_full) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      div_cnt_reg <= '0;
      tx_reg      <= UART_IDLE_LVL;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= UART_IDLE_LVL;
          if (!fifo_empty) begin
            shift_reg   <= pop_data;
            div_cnt_reg <= DIV_LAST;
            tx_reg      <= UART_START_LVL;
            state_reg   <= START;
          end
        end
        START: begin
          if (div_cnt_reg == '0) begin
            bit_idx_reg <= '0;
            div_cnt_reg <= DIV_LAST;
            tx_reg      <= shift_reg[0];
            state_reg   <= DATA;
          end else begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end
        end
        DATA: begin
          if (div_cnt_reg == '0) begin
            div_cnt_reg <= DIV_LAST;
            if (bit_idx_reg == 3'd7) begin
`ifdef PORT_UART_PARITY_EN
              tx_reg    <= ^shift_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= UART_IDLE_LVL;
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
            end
          end else begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end
        end
`ifdef PORT_UART_PARITY_EN
        PARITY: begin
          if (div_cnt_reg == '0) begin
            div_cnt_reg <= DIV_LAST;
            tx_reg      <= UART_IDLE_LVL;
            state_reg   <= STOP;
          end else begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end
        end
`endif
        STOP: begin
          tx_reg <= UART_IDLE_LVL;
          if (div_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end
        end
        default: begin
          tx_reg    <= UART_IDLE_LVL;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX       = tx_reg;
  assign bus.OVF      = ovf_reg;
  assign bus.FIFO_CNT = fifo_cnt;
  assign bus.BUSY     = (state_reg != IDLE) || (fifo_cnt != '0);

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx at CLK_DIV=4, FIFO_DEPTH=4; frames are checked cycle by cycle.
// Honours PORT_UART_PARITY_EN to expect the extra parity bit.
module tb_port_uart_tx;

  localparam int CD    = 4;
  localparam int DEPTH = 4;
`ifdef PORT_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  port_uart_tx_if #(.FIFO_DEPTH(DEPTH)) u_if ();

  port_uart_tx #(
    .CLK_DIV   (CD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(u_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef PORT_UART_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic wait_start(input string tag, input int budget, output int waited);
    waited = 0;
    while (u_if.TX !== 1'b0 && waited < budget) begin
      tick;
      waited++;
    end
    check({tag, "_start"}, {31'd0, u_if.TX}, 32'd0);
  endtask

  // Called with 'skip' frame cycles already elapsed since TX went low.
  task automatic check_frame(input string tag, input logic [7:0] d, input int skip);
    int bad;
    bad = 0;
    for (int j = skip; j < NBITS * CD; j++) begin
      if (u_if.TX !== frame_bit(d, j / CD)) bad++;
      tick;
    end
    $display("frame %s data=%02h bad_cycles=%0d at cycle %0d", tag, d, bad, cyc);
    check({tag, "_bits"}, bad, 0);
    check({tag, "_idle"}, {31'd0, u_if.TX}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lows, busys, w, s1, s2, s3;

    rst          = 1'b1;
    u_if.PORT_IN = 8'h00;
    repeat (3) tick;
    check("rst_tx",   {31'd0, u_if.TX},   32'd1);
    check("rst_busy", {31'd0, u_if.BUSY}, 32'd0);
    check("rst_ovf",  {31'd0, u_if.OVF},  32'd0);
    check("rst_cnt",  32'(u_if.FIFO_CNT), 32'd0);
    rst = 1'b0;

    // Constant port: no traffic.
    lows = 0; busys = 0;
    repeat (50) begin
      tick;
      if (u_if.TX === 1'b0) lows++;
      if (u_if.BUSY !== 1'b0) busys++;
    end
    check("idle_tx_lows",  lows,  0);
    check("idle_busy",     busys, 0);
    check("idle_cnt",      32'(u_if.FIFO_CNT), 32'd0);

    // Single value A5: push one edge, pop and start bit the next.
    u_if.PORT_IN = 8'hA5;
    tick;
    check("a5_cnt_push", 32'(u_if.FIFO_CNT), 32'd1);
    check("a5_busy",     {31'd0, u_if.BUSY}, 32'd1);
    check("a5_tx_wait",  {31'd0, u_if.TX},   32'd1);
    tick;
    check("a5_tx_fall",  {31'd0, u_if.TX},   32'd0);
    check("a5_cnt_pop",  32'(u_if.FIFO_CNT), 32'd0);
    check_frame("a5", 8'hA5, 0);
    check("a5_busy_end", {31'd0, u_if.BUSY}, 32'd0);

    // Three single-cycle values back to back.
    u_if.PORT_IN = 8'h01;
    tick;
    u_if.PORT_IN = 8'h02;
    tick;
    s1 = cyc;
    u_if.PORT_IN = 8'h03;
    tick;
    check("seq_cnt_peak", 32'(u_if.FIFO_CNT), 32'd2);
    check_frame("s01", 8'h01, 1);
    wait_start("s02", 10, w);
    s2 = cyc;
    check("s02_spacing", s2 - s1, NBITS * CD + 1);
    check_frame("s02", 8'h02, 0);
    wait_start("s03", 10, w);
    s3 = cyc;
    check("s03_spacing", s3 - s2, NBITS * CD + 1);
    check_frame("s03", 8'h03, 0);
    check("seq_busy_end", {31'd0, u_if.BUSY}, 32'd0);

    // Overflow: seven values, one popped, four queued, two dropped.
    for (int i = 0; i < 7; i++) begin
      u_if.PORT_IN = 8'h10 + 8'(i);
      tick;
    end
    check("ovf_cnt_full", 32'(u_if.FIFO_CNT), 32'd4);
    check("ovf_flag",     {31'd0, u_if.OVF},  32'd1);
    check_frame("o10", 8'h10, 5);
    for (int i = 1; i < 5; i++) begin
      wait_start("oq", 10, w);
      check_frame("oq", 8'h10 + 8'(i), 0);
    end
    repeat (5) tick;
    check("ovf_sticky",   {31'd0, u_if.OVF},  32'd1);
    check("ovf_busy_end", {31'd0, u_if.BUSY}, 32'd0);
    check("ovf_cnt_end",  32'(u_if.FIFO_CNT), 32'd0);

    // Reset in the middle of the data bits.
    u_if.PORT_IN = 8'h5A;
    wait_start("r5a", 10, w);
    repeat (3 * CD) tick;
    rst = 1'b1;
    tick;
    check("mid_rst_tx",   {31'd0, u_if.TX},   32'd1);
    check("mid_rst_busy", {31'd0, u_if.BUSY}, 32'd0);
    check("mid_rst_ovf",  {31'd0, u_if.OVF},  32'd0);
    check("mid_rst_cnt",  32'(u_if.FIFO_CNT), 32'd0);
    rst = 1'b0;
    lows = 0; busys = 0;
    repeat (60) begin
      tick;
      if (u_if.TX === 1'b0) lows++;
      if (u_if.BUSY !== 1'b0) busys++;
    end
    check("post_rst_lows", lows,  0);
    check("post_rst_busy", busys, 0);

    // Odd and even parity patterns.
    u_if.PORT_IN = 8'h07;
    wait_start("p07", 10, w);
    check("p07_latency", w, 2);
    check_frame("p07", 8'h07, 0);
    u_if.PORT_IN = 8'h03;
    wait_start("p03", 10, w);
    check_frame("p03", 8'h03, 0);
    check("end_busy", {31'd0, u_if.BUSY}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
